// File: rtl/mac_array_seq_if.sv
// Upstream word stream into the MAC array sequencer: one bw-bit word per array row.
// The source holds in_data/in_valid until in_ready; in_ready never depends on in_valid.
interface mac_array_seq_if #(
    parameter int bw  = 4,
    parameter int row = 8
);
    logic [row*bw-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/mac_array_seq.sv
// West-edge sequencer: optional clear+kernel load, 2*nij execute words, drain, done pulse.
// Latency: handshake at k reaches row r at k+1+r; backpressure: bubbles issue code 00, counters hold.
module mac_array_seq #(
    parameter int bw     = 4,
    parameter int row    = 8,
    parameter int col    = 8,
    parameter int cnt_bw = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                reload,
    input  logic [cnt_bw-1:0]   nij,
    mac_array_seq_if.slave      up,
    output logic                tile_rst,
    output logic [2*row-1:0]    inst_w,
    output logic [row*bw-1:0]   data_w,
    output logic                busy,
    output logic                done
);
    localparam int cw = cnt_bw + 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLR   = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_EXEC  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    localparam logic [cw-1:0] load_last  = cw'(2 * col - 1);
    localparam logic [cw-1:0] drain_last = cw'(row + col - 1);

    logic [2:0]        state;
    logic [cw-1:0]     cnt;
    logic [cnt_bw-1:0] nij_q;
    logic [cw-1:0]     exec_last;
    logic              hs;
    logic [1:0]        issue_code;
    logic [1:0]        inst_sr [row];

    // 2*nij is formed one bit wider so a full-scale nij cannot wrap
    assign exec_last = {nij_q, 1'b0} - cw'(1);

    assign up.in_ready = (state == ST_LOAD) || (state == ST_EXEC);
    assign hs          = up.in_valid && up.in_ready;
    assign issue_code  = !hs ? 2'b00 : (state == ST_LOAD) ? 2'b01 : 2'b10;

    assign busy     = (state != ST_IDLE);
    assign tile_rst = reset || (state == ST_CLR);
    assign done     = !reset && (state == ST_DRAIN) && (cnt == drain_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            nij_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        nij_q <= nij;
                        if (reload)
                            state <= ST_CLR;
                        else if (nij != '0)
                            state <= ST_EXEC;
                        else
                            state <= ST_DRAIN;
                    end
                end
                ST_CLR: begin
                    state <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (hs) begin
                        if (cnt == load_last) begin
                            cnt   <= '0;
                            state <= (nij_q != '0) ? ST_EXEC : ST_DRAIN;
                        end else begin
                            cnt <= cnt + cw'(1);
                        end
                    end
                end
                ST_EXEC: begin
                    if (hs) begin
                        if (cnt == exec_last) begin
                            cnt   <= '0;
                            state <= ST_DRAIN;
                        end else begin
                            cnt <= cnt + cw'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (cnt == drain_last) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + cw'(1);
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Instruction skew chain keeps shifting in every state so a job's tail drains out
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < row; r++)
                inst_sr[r] <= 2'b00;
        end else begin
            inst_sr[0] <= issue_code;
            for (int r = 1; r < row; r++)
                inst_sr[r] <= inst_sr[r-1];
        end
    end

    for (genvar r = 0; r < row; r++) begin : g_row
        logic [bw-1:0] dat_sr [r+1];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int s = 0; s <= r; s++)
                    dat_sr[s] <= '0;
            end else begin
                dat_sr[0] <= hs ? up.in_data[r*bw +: bw] : '0;
                for (int s = 1; s <= r; s++)
                    dat_sr[s] <= dat_sr[s-1];
            end
        end

        assign inst_w[2*r +: 2]  = inst_sr[r];
        assign data_w[r*bw +: bw] = dat_sr[r];
    end
endmodule
